pc_select_unit: RTL and testbench

//  Parametrised fetch-PC register for the pipelined Y86 core, successor to the single-cycle PC latch.

---
 rtl/pc_select_unit.sv | 98 +++++++++
 tb/tb_pc_select_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_select_unit.sv
// Fetch-PC register: prediction advance, stall hold, mispredict/RET redirect, HALT.
// Ports: clk, rst (async low), pred/stall/ret/halt/mispredict in; pc, pc_valid, state, redirect_cnt out.
module pc_select_unit #(
  parameter int            AW       = 48,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    pred_pc,
  input  logic             pred_valid,
  input  logic             stall,
  input  logic             ret_fetched,
  input  logic             halt_req,
  input  logic             mispredict,
  input  logic [AW-1:0]    mispredict_pc,
  input  logic             ret_done,
  input  logic [AW-1:0]    ret_pc,
  output logic [AW-1:0]    pc,
  output logic             pc_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    RET_WAIT = 2'b01,
    HALT     = 2'b10,
    BAD      = 2'b11
  } st_t;

  st_t             st_q, st_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic            redir;

  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    redir = 1'b0;
    unique case (st_q)
      RUN: begin
        if (mispredict) begin
          pc_d  = mispredict_pc;
          redir = 1'b1;
        end else if (stall) begin
          st_d = RUN;
        end else if (halt_req) begin
          st_d = HALT;
        end else if (ret_fetched) begin
          st_d = RET_WAIT;
        end else if (pred_valid) begin
          pc_d = pred_pc;
        end
      end
      RET_WAIT: begin
        // a mispredict means the RET itself was on the wrong path
        if (mispredict) begin
          pc_d  = mispredict_pc;
          st_d  = RUN;
          redir = 1'b1;
        end else if (ret_done) begin
          pc_d  = ret_pc;
          st_d  = RUN;
          redir = 1'b1;
        end
      end
      HALT: begin
        if (mispredict) begin
          pc_d  = mispredict_pc;
          st_d  = RUN;
          redir = 1'b1;
        end
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= RUN;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      // saturating count
      if (redir && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc           = pc_q;
  assign state        = st_q;
  assign pc_valid     = (st_q == RUN);
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Self-checking bench for pc_select_unit: directed scenarios plus random traffic
// against a behavioural model; a second instance with a 2-bit counter checks saturation.
module tb_pc_select_unit;

  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pred_pc = '0;
  logic          pred_valid = 1'b0;
  logic          stall = 1'b0;
  logic          ret_fetched = 1'b0;
  logic          halt_req = 1'b0;
  logic          mispredict = 1'b0;
  logic [AW-1:0] mispredict_pc = '0;
  logic          ret_done = 1'b0;
  logic [AW-1:0] ret_pc = '0;

  logic [AW-1:0] pc, pc2;
  logic          pc_valid, pc_valid2;
  logic [1:0]    state, state2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  int checks = 0;
  int errors = 0;

  // model: 0 run, 1 waiting for return address, 2 halted
  logic [AW-1:0] m_pc;
  int            m_st;
  int            m_cnt;

  always #5 clk = ~clk;

  pc_select_unit #(.AW(AW), .RESET_PC(48'h100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_valid(pred_valid),
    .stall(stall), .ret_fetched(ret_fetched), .halt_req(halt_req),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .ret_done(ret_done), .ret_pc(ret_pc), .pc(pc), .pc_valid(pc_valid),
    .state(state), .redirect_cnt(cnt)
  );

  pc_select_unit #(.AW(AW), .RESET_PC(48'h100), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_valid(pred_valid),
    .stall(stall), .ret_fetched(ret_fetched), .halt_req(halt_req),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .ret_done(ret_done), .ret_pc(ret_pc), .pc(pc2), .pc_valid(pc_valid2),
    .state(state2), .redirect_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c16, c2;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c2  = (m_cnt > 3) ? 3 : m_cnt;
    chk({tag, ".pc"}, 64'(pc), 64'(m_pc));
    chk({tag, ".state"}, 64'(state), 64'(m_st));
    chk({tag, ".pc_valid"}, 64'(pc_valid), 64'(m_st == 0));
    chk({tag, ".cnt"}, 64'(cnt), 64'(c16));
    chk({tag, ".pc2"}, 64'(pc2), 64'(m_pc));
    chk({tag, ".state2"}, 64'(state2), 64'(m_st));
    chk({tag, ".cnt2"}, 64'(cnt2), 64'(c2));
  endtask

  task automatic model_reset();
    m_pc  = 48'h100;
    m_st  = 0;
    m_cnt = 0;
  endtask

  task automatic redirect(input logic [AW-1:0] t);
    m_pc  = t;
    m_st  = 0;
    m_cnt = m_cnt + 1;
  endtask

  task automatic model_edge();
    if (m_st == 0) begin
      if (mispredict)       redirect(mispredict_pc);
      else if (stall)       m_pc = m_pc;
      else if (halt_req)    m_st = 2;
      else if (ret_fetched) m_st = 1;
      else if (pred_valid)  m_pc = pred_pc;
    end else if (m_st == 1) begin
      if (mispredict)    redirect(mispredict_pc);
      else if (ret_done) redirect(ret_pc);
    end else begin
      if (mispredict) redirect(mispredict_pc);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    pred_valid = 0; stall = 0; ret_fetched = 0; halt_req = 0;
    mispredict = 0; ret_done = 0;
  endtask

  function automatic logic [AW-1:0] rnd_pc();
    return AW'({$urandom, $urandom});
  endfunction

  initial begin
    // T1: async reset mid-cycle, no clock edge needed
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("t1_reset");
    chk("t1_pc_const", 64'(pc), 64'h100);
    #2 rst = 1'b1;
    #1;
    check_all("t1_release");

    // T2: advance with a stall in between
    pred_valid = 1; pred_pc = 48'h102;
    step("t2_a");
    chk("t2_pc_102", 64'(pc), 64'h102);
    stall = 1; pred_pc = 48'h10C;
    step("t2_stall");
    chk("t2_hold_102", 64'(pc), 64'h102);
    stall = 0;
    step("t2_b");
    chk("t2_pc_10c", 64'(pc), 64'h10C);

    // T3: mispredict beats stall and halt
    idle();
    stall = 1; halt_req = 1; mispredict = 1; mispredict_pc = 48'h2A;
    step("t3");
    chk("t3_pc", 64'(pc), 64'h2A);
    chk("t3_cnt", 64'(cnt), 64'd1);

    // T4: RET wait then resume under stall
    idle();
    pred_valid = 1; pred_pc = 48'h40;
    step("t4_to40");
    idle();
    ret_fetched = 1;
    step("t4_ret");
    chk("t4_state", 64'(state), 64'd1);
    idle();
    pred_valid = 1; pred_pc = 48'h999; halt_req = 1;
    for (int i = 0; i < 3; i++) step("t4_wait");
    idle();
    ret_done = 1; ret_pc = 48'h80; stall = 1;
    step("t4_done");
    chk("t4_pc80", 64'(pc), 64'h80);
    chk("t4_cnt", 64'(cnt), 64'd2);

    // T5: HALT ignores everything but mispredict
    idle();
    halt_req = 1;
    step("t5_halt");
    chk("t5_state", 64'(state), 64'd2);
    for (int i = 0; i < 5; i++) begin
      idle();
      pred_valid = 1; pred_pc = rnd_pc();
      ret_done = 1; ret_pc = rnd_pc();
      ret_fetched = 1'($urandom);
      stall = 1'($urandom);
      step("t5_ignored");
    end
    idle();
    mispredict = 1; mispredict_pc = 48'h14;
    step("t5_exit");
    chk("t5_pc14", 64'(pc), 64'h14);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      pred_valid    = ($urandom_range(3, 0) != 0);
      pred_pc       = rnd_pc();
      stall         = ($urandom_range(3, 0) == 0);
      ret_fetched   = ($urandom_range(7, 0) == 0);
      halt_req      = ($urandom_range(15, 0) == 0);
      mispredict    = ($urandom_range(9, 0) == 0);
      mispredict_pc = rnd_pc();
      ret_done      = ($urandom_range(3, 0) == 0);
      ret_pc        = rnd_pc();
      step("rand");
    end

    // T6: reset while in RET_WAIT, then saturate the small counter
    idle();
    mispredict = 1; mispredict_pc = 48'h60;
    step("t6_run");
    idle();
    ret_fetched = 1;
    step("t6_ret");
    chk("t6_in_wait", 64'(state), 64'd1);
    idle();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_reset");
    chk("t6_pc_const", 64'(pc), 64'h100);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mispredict = 1; mispredict_pc = 48'h200 + 48'(i);
      step("t6_redir");
    end
    chk("t6_cnt2_sat", 64'(cnt2), 64'd3);
    chk("t6_cnt16", 64'(cnt), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
